// File: rtl/complete_arbiter.sv
// Completion arbiter: one-entry holding buffer per functional unit, round-robin
// selection onto the single registered ROB-complete / CDB broadcast port.
module complete_arbiter #(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32,
  parameter int ROB_SZ = 32,
  parameter int PTAG_W = 6,
  localparam int RW    = $clog2(ROB_SZ),
  localparam int PW    = $clog2(NUM_FU)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*RW-1:0]     fu_rob_idx,
  input  logic [NUM_FU*PTAG_W-1:0] fu_tag,
  input  logic [NUM_FU-1:0]        fu_tag_valid,
  input  logic [NUM_FU*XLEN-1:0]   fu_result,
  input  logic [NUM_FU*XLEN-1:0]   fu_rs2_value,
  input  logic [NUM_FU-1:0]        fu_take_branch,
  output logic                     complete_en,
  output logic [RW-1:0]            complete_idx,
  output logic [XLEN-1:0]          result,
  output logic [XLEN-1:0]          rs2_value,
  output logic                     take_branch,
  output logic                     cdb_valid,
  output logic [PTAG_W-1:0]        cdb_tag
);

  // Handshake: a completion transfers from FU i on a rising edge where
  // fu_valid[i] && fu_ready[i]; fu_ready never looks at fu_valid.

  logic [NUM_FU-1:0] hold_valid;
  logic [RW-1:0]     hold_idx       [NUM_FU];
  logic [PTAG_W-1:0] hold_tag       [NUM_FU];
  logic              hold_tag_valid [NUM_FU];
  logic [XLEN-1:0]   hold_result    [NUM_FU];
  logic [XLEN-1:0]   hold_rs2       [NUM_FU];
  logic              hold_branch    [NUM_FU];

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     grant_idx;
  logic              grant_any;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] accept;

  // Scan from rr_ptr upward; the PW-bit add wraps because NUM_FU is a power of 2.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = rr_ptr + PW'(k);
      if (!grant_any && hold_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    grant[grant_idx] = grant_any;
  end

  // A granted buffer can refill in the same cycle, so a single FU streams 1/cycle.
  assign fu_ready = {NUM_FU{!squash}} & (~hold_valid | grant);
  assign accept   = fu_valid & fu_ready;

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      hold_valid <= '0;
    end else begin
      hold_valid <= (hold_valid & ~grant) | accept;
    end
  end

  // Payload needs no reset: it is only observed while hold_valid is set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        hold_idx[i]       <= fu_rob_idx[i*RW +: RW];
        hold_tag[i]       <= fu_tag[i*PTAG_W +: PTAG_W];
        hold_tag_valid[i] <= fu_tag_valid[i];
        hold_result[i]    <= fu_result[i*XLEN +: XLEN];
        hold_rs2[i]       <= fu_rs2_value[i*XLEN +: XLEN];
        hold_branch[i]    <= fu_take_branch[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr       <= '0;
      complete_en  <= 1'b0;
      cdb_valid    <= 1'b0;
      complete_idx <= '0;
      result       <= '0;
      rs2_value    <= '0;
      take_branch  <= 1'b0;
      cdb_tag      <= '0;
    end else if (squash || !grant_any) begin
      // Payload outputs keep their last value; rr_ptr is untouched by squash.
      complete_en <= 1'b0;
      cdb_valid   <= 1'b0;
    end else begin
      rr_ptr       <= grant_idx + PW'(1);
      complete_en  <= 1'b1;
      cdb_valid    <= hold_tag_valid[grant_idx];
      complete_idx <= hold_idx[grant_idx];
      result       <= hold_result[grant_idx];
      rs2_value    <= hold_rs2[grant_idx];
      take_branch  <= hold_branch[grant_idx];
      cdb_tag      <= hold_tag[grant_idx];
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Bench for complete_arbiter: directed scenarios plus random traffic, checked by a
// scoreboard fed from an abstract per-FU holding/round-robin model.
module tb_complete_arbiter;
  localparam int N  = 4;
  localparam int XL = 32;
  localparam int RW = 5;
  localparam int TW = 6;
  localparam int EW = RW + XL + XL + 1 + 1 + TW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic squash = 1'b0;
  logic [N-1:0] fu_valid = '0, fu_ready, fu_tag_valid = '0, fu_take_branch = '0;
  logic [N*RW-1:0] fu_rob_idx = '0;
  logic [N*TW-1:0] fu_tag = '0;
  logic [N*XL-1:0] fu_result = '0, fu_rs2_value = '0;
  logic complete_en, take_branch, cdb_valid;
  logic [RW-1:0] complete_idx;
  logic [XL-1:0] result, rs2_value;
  logic [TW-1:0] cdb_tag;

  complete_arbiter #(.NUM_FU(N), .XLEN(XL), .ROB_SZ(32), .PTAG_W(TW)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_rob_idx(fu_rob_idx),
    .fu_tag(fu_tag), .fu_tag_valid(fu_tag_valid), .fu_result(fu_result),
    .fu_rs2_value(fu_rs2_value), .fu_take_branch(fu_take_branch),
    .complete_en(complete_en), .complete_idx(complete_idx), .result(result),
    .rs2_value(rs2_value), .take_branch(take_branch), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int exp_cyc_q[$];

  always @(negedge clock) begin
    if (mon_on) begin
      if (complete_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_complete cyc %0d: got idx %0d, expected no completion", cyc, complete_idx);
        end else begin
          logic [EW-1:0] e, a;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          a  = {complete_idx, result, rs2_value, take_branch, cdb_valid, cdb_tag};
          if (a !== e || ec != cyc) begin
            errors++;
            $display("FAIL completion cyc %0d: got %h at cyc %0d, expected %h at cyc %0d", cyc, a, cyc, e, ec);
          end
        end
      end else begin
        checks++;
        if (cdb_valid !== 1'b0) begin
          errors++;
          $display("FAIL cdb_valid_idle cyc %0d: got %b expected 0", cyc, cdb_valid);
        end
        if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
          errors++;
          $display("FAIL missing_complete cyc %0d: got complete_en %b, expected idx %0d", cyc, complete_en, exp_q[0][EW-1 -: RW]);
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Each FU owns at most one waiting completion; the oldest-priority pointer
  // moves to one past whoever was last serviced.
  int m_v[N];
  logic [RW-1:0] m_idx[N];
  logic [TW-1:0] m_tag[N];
  logic m_tv[N], m_br[N];
  logic [XL-1:0] m_res[N], m_rs2[N];
  int m_rr = 0;

  task automatic model_step();
    int g;
    logic [N-1:0] rdy;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (g < 0 && m_v[j] != 0) g = j;
    end
    for (int i = 0; i < N; i++) rdy[i] = !squash && (m_v[i] == 0 || g == i);
    if (!reset) begin
      checks++;
      if (fu_ready !== rdy) begin
        errors++;
        $display("FAIL fu_ready cyc %0d: got %b expected %b", cyc, fu_ready, rdy);
      end
    end
    if (reset || squash) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      if (reset) m_rr = 0;
    end else begin
      if (g >= 0) begin
        exp_q.push_back({m_idx[g], m_res[g], m_rs2[g], m_br[g], m_tv[g], m_tag[g]});
        exp_cyc_q.push_back(cyc + 1);
        m_rr = (g + 1) % N;
        m_v[g] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (fu_valid[i] && rdy[i]) begin
          m_v[i]   = 1;
          m_idx[i] = fu_rob_idx[i*RW +: RW];
          m_tag[i] = fu_tag[i*TW +: TW];
          m_tv[i]  = fu_tag_valid[i];
          m_res[i] = fu_result[i*XL +: XL];
          m_rs2[i] = fu_rs2_value[i*XL +: XL];
          m_br[i]  = fu_take_branch[i];
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
    #1;
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_fu(input int i, input logic [RW-1:0] idx, input logic [TW-1:0] tag,
                        input logic tv, input logic [XL-1:0] res, input logic [XL-1:0] rs2,
                        input logic br);
    fu_valid[i]             = 1'b1;
    fu_rob_idx[i*RW +: RW]  = idx;
    fu_tag[i*TW +: TW]      = tag;
    fu_tag_valid[i]         = tv;
    fu_result[i*XL +: XL]   = res;
    fu_rs2_value[i*XL +: XL] = rs2;
    fu_take_branch[i]       = br;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) m_v[i] = 0;
    @(posedge clock);
    #1;
    idle(2);
    reset = 1'b0;
    mon_on = 1'b1;
    chk("reset_complete_en", 64'(complete_en), 64'd0);
    chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset_complete_idx", 64'(complete_idx), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_rs2_value", 64'(rs2_value), 64'd0);
    chk("reset_take_branch", 64'(take_branch), 64'd0);
    chk("reset_cdb_tag", 64'(cdb_tag), 64'd0);

    // Single completion from FU1.
    set_fu(1, 5'd5, 6'd12, 1'b1, 32'hDEAD, 32'h0, 1'b0);
    tick();
    fu_valid = '0;
    idle(4);

    // All four FUs at once with rr_ptr at 0.
    do_reset();
    for (int i = 0; i < N; i++) set_fu(i, 5'(i), 6'(20 + i), 1'b1, 32'h100 + 32'(i), 32'h0, 1'b0);
    tick();
    fu_valid = '0;
    idle(6);

    // FU2 streams six back-to-back completions.
    for (int n = 0; n < 6; n++) begin
      set_fu(2, 5'(10 + n), 6'(30 + n), 1'b1, 32'h2000 + 32'(n), 32'h55 + 32'(n), n[0]);
      tick();
    end
    fu_valid = '0;
    idle(4);

    // FU0 and FU3 continuously valid; FU3 writes no register.
    for (int n = 0; n < 8; n++) begin
      set_fu(0, 5'(16 + n), 6'(40 + n), 1'b1, 32'h3000 + 32'(n), 32'h0, 1'b0);
      set_fu(3, 5'(24 + n), 6'(50 + n), 1'b0, 32'h4000 + 32'(n), 32'h77, 1'b1);
      tick();
    end
    fu_valid = '0;
    idle(4);

    // Squash with three buffers held and a new FU0 request in the squash cycle.
    for (int i = 1; i < N; i++) set_fu(i, 5'(i + 4), 6'(i), 1'b1, 32'h500 + 32'(i), 32'h0, 1'b0);
    tick();
    fu_valid = '0;
    squash = 1'b1;
    set_fu(0, 5'd9, 6'd9, 1'b1, 32'hBAD0, 32'h0, 1'b0);
    tick();
    squash = 1'b0;
    fu_valid = '0;
    idle(4);

    // Reset while two buffers are held and a completion is being presented.
    for (int i = 0; i < 3; i++) set_fu(i, 5'(i + 20), 6'(i + 1), 1'b1, 32'h600 + 32'(i), 32'h0, 1'b0);
    tick();
    fu_valid = '0;
    tick();
    do_reset();
    chk("midreset_complete_en", 64'(complete_en), 64'd0);
    set_fu(3, 5'd31, 6'd63, 1'b1, 32'hCAFE, 32'h1234, 1'b1);
    tick();
    fu_valid = '0;
    idle(4);

    // Random traffic with occasional squash and reset.
    for (int n = 0; n < 400; n++) begin
      reset  = ($urandom_range(0, 99) == 0);
      squash = !reset && ($urandom_range(0, 29) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0)
          set_fu(i, 5'($urandom), 6'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
        else
          fu_valid[i] = 1'b0;
      end
      tick();
    end
    reset = 1'b0;
    squash = 1'b0;
    fu_valid = '0;
    idle(6);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion of stimulus");
    $fatal(1);
  end
endmodule
